// File: rtl/latq_bank_pkg.sv
// Shared types and constants for the latq bank write/read schedulers.
// The state encoding is fixed at 2 bits so downstream tools see a stable layout.
package latq_bank_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_W     = 8;
  localparam int DEF_AW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Never returns less than 1 so a 1-requester index still has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/latq_bank_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// scanning upward modulo N. Shared by the bank write and read schedulers.
module rr_arb
  import latq_bank_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic [N-1:0] req_rot;
  logic [PW:0]  off;
  logic [PW:0]  raw;
  logic [PW:0]  wrapped;
  logic         found;

  // Rotate so bit 0 is the requester the pointer currently favours.
  assign req_rot = N'({req, req} >> ptr);

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        off   = (PW+1)'(k);
        found = 1'b1;
      end
    end
    raw     = {1'b0, ptr} + off;
    wrapped = (raw >= (PW+1)'(N)) ? raw - (PW+1)'(N) : raw;
    idx     = PW'(wrapped);
    grant   = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/latq_bank_wr_sched.sv
// Write scheduler for a latq latch bank: round-robin grant, flop-staged data and
// a SETUP/OPEN/HOLD sequence so each latch enable pulse is glitch-free.
module latq_bank_wr_sched
  import latq_bank_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W,
  parameter int AW    = DEF_AW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N-1:0]     req,
  input  logic [N*AW-1:0]  addr,
  input  logic [N*W-1:0]   wdata,
  output logic [N-1:0]     ack,
  output logic             err,
  output logic [DEPTH-1:0] E,
  output logic [W-1:0]     D,
  output logic             busy
);

  localparam int PW = clog2(N);

  state_t           state_reg, state_next;
  logic [W-1:0]     d_reg;
  logic [AW-1:0]    stage_addr_reg;
  logic [PW-1:0]    stage_id_reg;
  logic [PW-1:0]    rr_ptr_reg;
  logic             oor_reg;
  logic [DEPTH-1:0] e_reg, e_next;
  logic [N-1:0]     ack_reg, ack_next;
  logic             err_reg;
  logic             busy_reg;

  logic [N-1:0]     grant;
  logic [PW-1:0]    grant_idx;
  logic [AW-1:0]    sel_addr;
  logic [W-1:0]     sel_wdata;
  logic             sel_oor;
  logic             start;
  logic [PW-1:0]    ptr_next;

  rr_arb #(.N(N), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_addr  = sel_addr  | addr[i*AW +: AW];
        sel_wdata = sel_wdata | wdata[i*W +: W];
      end
    end
  end

  assign sel_oor  = ({1'b0, sel_addr} >= (AW+1)'(DEPTH));
  assign ptr_next = (stage_id_reg == PW'(N-1)) ? '0 : stage_id_reg + PW'(1);

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = SETUP;
          start      = 1'b1;
        end
      end
      SETUP:   state_next = OPEN;
      OPEN:    state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Enables and acks are decoded one cycle early so the outputs are pure flops.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_e
    assign e_next[gi] = (state_reg == SETUP) && !oor_reg && (stage_addr_reg == AW'(gi));
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ack
    assign ack_next[gi] = (state_reg == OPEN) && (stage_id_reg == PW'(gi));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_reg          <= '0;
      stage_addr_reg <= '0;
      stage_id_reg   <= '0;
      oor_reg        <= 1'b0;
      rr_ptr_reg     <= '0;
      e_reg          <= '0;
      ack_reg        <= '0;
      err_reg        <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      e_reg    <= e_next;
      ack_reg  <= ack_next;
      err_reg  <= (state_reg == OPEN) && oor_reg;
      busy_reg <= (state_next != IDLE);
      if (start) begin
        d_reg          <= sel_wdata;
        stage_addr_reg <= sel_addr;
        stage_id_reg   <= grant_idx;
        oor_reg        <= sel_oor;
      end
      if (state_reg == HOLD) rr_ptr_reg <= ptr_next;
    end
  end

  assign E    = e_reg;
  assign D    = d_reg;
  assign ack  = ack_reg;
  assign err  = err_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_latq_bank_wr_sched.sv
// Self-checking bench for latq_bank_wr_sched: directed scenarios plus random
// requesters, checked every cycle against a transaction-timeline model.
module tb_latq_bank_wr_sched;

  localparam int N     = 4;
  localparam int DEPTH = 12;
  localparam int W     = 8;
  localparam int AW    = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [N-1:0]     req;
  logic [N*AW-1:0]  addr;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     ack;
  logic             err;
  logic [DEPTH-1:0] E;
  logic [W-1:0]     D;
  logic             busy;

  latq_bank_wr_sched #(.N(N), .DEPTH(DEPTH), .W(W), .AW(AW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .req   (req),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .err   (err),
    .E     (E),
    .D     (D),
    .busy  (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a grant at edge g puts data on D from then on, E in the cycle after
  // edge g+1, ack/err after edge g+2, and frees the scheduler for edge g+4.
  int           cyc;
  int           g_edge;
  int           m_ptr;
  int           m_id;
  int           m_addr;
  logic [W-1:0] m_data;
  logic [W-1:0] m_d;
  bit           m_oor;
  int           txn = 0;
  bit           sticky [N];
  logic [W-1:0] model_bank [DEPTH];
  logic [W-1:0] emul_bank  [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc    = 0;
    g_edge = -100;
    m_ptr  = 0;
    m_id   = 0;
    m_addr = 0;
    m_data = '0;
    m_d    = '0;
    m_oor  = 1'b0;
  endtask

  task automatic model_edge();
    bit found;
    found = 1'b0;
    if (cyc - g_edge >= 4 && req != '0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && req[i]) begin
          found  = 1'b1;
          m_id   = i;
          m_addr = int'(addr[i*AW +: AW]);
          m_data = wdata[i*W +: W];
          m_oor  = (m_addr >= DEPTH);
          m_d    = m_data;
          m_ptr  = (i + 1) % N;
          g_edge = cyc;
          txn++;
          $display("txn %0d: grant id=%0d addr=%0d data=%02h oor=%0d", txn, m_id, m_addr, m_data, m_oor);
        end
      end
    end
  endtask

  task automatic check_cycle();
    int               k;
    logic [DEPTH-1:0] exp_e;
    logic [N-1:0]     exp_ack;
    k       = cyc - g_edge;
    exp_e   = '0;
    exp_ack = '0;
    if (k == 1 && !m_oor) begin
      exp_e[m_addr]      = 1'b1;
      model_bank[m_addr] = m_data;
    end
    if (k == 2) exp_ack[m_id] = 1'b1;
    check("E",    64'(E),    64'(exp_e));
    check("ack",  64'(ack),  64'(exp_ack));
    check("err",  64'(err),  64'(k == 2 && m_oor));
    check("busy", 64'(busy), 64'(k >= 0 && k <= 2));
    check("D",    64'(D),    64'(m_d));
    for (int i = 0; i < DEPTH; i++) begin
      if (E[i]) emul_bank[i] = D;
    end
  endtask

  task automatic agents(input bit rnd);
    int k;
    k = cyc - g_edge;
    for (int i = 0; i < N; i++) begin
      if (ack[i] && !sticky[i]) req[i] = 1'b0;
    end
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && i == m_id && k >= 0 && k <= 2 && $urandom_range(0, 1) == 1) begin
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*W +: W]  = W'($urandom);
        end else if (!req[i] && !ack[i] && $urandom_range(0, 2) == 0) begin
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*W +: W]  = W'($urandom);
          req[i]           = 1'b1;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      cyc++;
      model_edge();
      @(negedge CLK);
      check_cycle();
      agents(rnd);
    end
  endtask

  task automatic set_req(input int i, input int a, input logic [W-1:0] d);
    addr[i*AW +: AW] = AW'(a);
    wdata[i*W +: W]  = d;
    req[i]           = 1'b1;
  endtask

  initial begin
    req   = '0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) sticky[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      model_bank[i] = '0;
      emul_bank[i]  = '0;
    end
    model_reset();

    repeat (3) @(negedge CLK);
    check("rst_E",    64'(E),    64'(0));
    check("rst_D",    64'(D),    64'(0));
    check("rst_ack",  64'(ack),  64'(0));
    check("rst_err",  64'(err),  64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    RST = 1'b0;

    // Single write, then a data change one cycle after the grant.
    set_req(0, 5, 8'hA5);
    run_cycles(6, 1'b0);
    set_req(0, 2, 8'h11);
    run_cycles(1, 1'b0);
    wdata[0 +: W] = 8'hFF;
    run_cycles(5, 1'b0);

    // Out-of-range address.
    set_req(1, 14, 8'h77);
    run_cycles(6, 1'b0);

    // Full contention with ack-driven drops.
    for (int i = 0; i < N; i++) set_req(i, 8 + i, W'(8'h10 * i + 1));
    run_cycles(18, 1'b0);

    // Two permanently asserted requesters must alternate.
    sticky[0] = 1'b1;
    sticky[2] = 1'b1;
    set_req(0, 1, 8'h21);
    set_req(2, 4, 8'h42);
    run_cycles(16, 1'b0);
    sticky[0] = 1'b0;
    sticky[2] = 1'b0;
    req = '0;
    run_cycles(5, 1'b0);

    // Random requesters, including changes to in-flight inputs.
    run_cycles(400, 1'b1);
    req = '0;
    run_cycles(6, 1'b0);

    // Reset during OPEN: E must clear without a clock edge and no ack follows.
    set_req(0, 3, 8'h5C);
    run_cycles(2, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_E",    64'(E),    64'(0));
    check("rst_mid_ack",  64'(ack),  64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_D",    64'(D),    64'(0));
    req[0] = 1'b0;
    set_req(3, 7, 8'h3C);
    @(posedge CLK);
    @(negedge CLK);
    check("rst_hold_E",   64'(E),   64'(0));
    check("rst_hold_ack", 64'(ack), 64'(0));
    RST = 1'b0;
    model_reset();
    run_cycles(6, 1'b0);

    for (int i = 0; i < DEPTH; i++) check($sformatf("bank[%0d]", i), 64'(emul_bank[i]), 64'(model_bank[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
